// File: rtl/bisr_alloc_if.sv
// Host, eNVM, weight-memory and allocator signals of the BISR allocation controller.
// master: the controller; slave: the surrounding fabric.
interface bisr_alloc_if #(
  parameter int unsigned SYSTOLIC_SIZE = 8,
  parameter int unsigned WEIGHT_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
);
  localparam int unsigned PAT_W = SYSTOLIC_SIZE * SYSTOLIC_SIZE;
  localparam int unsigned ROW_W = SYSTOLIC_SIZE * WEIGHT_WIDTH;

  logic                  start;
  logic                  abort;
  logic                  envm_rdy;
  logic [PAT_W-1:0]      envm_pattern;
  logic                  envm_wr_en;
  logic [PAT_W-1:0]      envm_faulty_patterns_flat;
  logic                  wmem_rd_en;
  logic [ADDR_WIDTH-1:0] wmem_rd_addr;
  logic [ROW_W-1:0]      wmem_rd_data;
  logic                  weight_start;
  logic                  weight_valid;
  logic [ROW_W-1:0]      input_weights;
  logic                  recovery_done;
  logic                  recovery_success;
  logic                  stall;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  act_valid;
  logic                  busy;
  logic                  done;
  logic                  fail;

  modport master (
    input  start, abort, envm_rdy, envm_pattern, wmem_rd_data,
           recovery_done, recovery_success, stall,
    output envm_wr_en, envm_faulty_patterns_flat, wmem_rd_en, wmem_rd_addr,
           weight_start, weight_valid, input_weights, read_addr, act_valid,
           busy, done, fail
  );

  modport slave (
    output start, abort, envm_rdy, envm_pattern, wmem_rd_data,
           recovery_done, recovery_success, stall,
    input  envm_wr_en, envm_faulty_patterns_flat, wmem_rd_en, wmem_rd_addr,
           weight_start, weight_valid, input_weights, read_addr, act_valid,
           busy, done, fail
  );
endinterface

// File: rtl/bisr_alloc_controller.sv
// Sequences one BISR allocation: load eNVM fault map, stream weight rows to the
// allocator, check the recovery verdict, then walk the row read addresses.
module bisr_alloc_controller #(
  parameter int unsigned SYSTOLIC_SIZE = 8,
  parameter int unsigned WEIGHT_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
  input logic          clk,
  input logic          rst_n,
  bisr_alloc_if.master bus
);
  localparam int unsigned           PAT_W    = SYSTOLIC_SIZE * SYSTOLIC_SIZE;
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
  localparam logic [1:0]            CHK_LAST = 2'd3;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD_FAULT = 3'd1;
  localparam logic [2:0] S_INIT       = 3'd2;
  localparam logic [2:0] S_FETCH      = 3'd3;
  localparam logic [2:0] S_DRAIN      = 3'd4;
  localparam logic [2:0] S_CHECK      = 3'd5;
  localparam logic [2:0] S_RUN        = 3'd6;
  localparam logic [2:0] S_FINISH     = 3'd7;

  logic [2:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] row_cnt, row_nxt;
  logic [ADDR_WIDTH-1:0] run_cnt, run_nxt;
  logic [1:0]            chk_cnt, chk_nxt;

  logic                  wr_en_q, wr_en_nxt;
  logic [PAT_W-1:0]      pat_q, pat_nxt;
  logic                  rd_en_q, rd_en_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_nxt;
  logic                  ws_q, ws_nxt;
  logic                  wv_q, wv_nxt;
  logic                  act_q, act_nxt;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_nxt;
  logic                  busy_q, busy_nxt;
  logic                  done_q, done_nxt;
  logic                  fail_q, fail_nxt;

  // State, counters and every status/strobe register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row_cnt   <= '0;
      run_cnt   <= '0;
      chk_cnt   <= '0;
      wr_en_q   <= 1'b0;
      pat_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      ws_q      <= 1'b0;
      wv_q      <= 1'b0;
      act_q     <= 1'b0;
      raddr_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      row_cnt   <= row_nxt;
      run_cnt   <= run_nxt;
      chk_cnt   <= chk_nxt;
      wr_en_q   <= wr_en_nxt;
      pat_q     <= pat_nxt;
      rd_en_q   <= rd_en_nxt;
      rd_addr_q <= rd_addr_nxt;
      ws_q      <= ws_nxt;
      wv_q      <= wv_nxt;
      act_q     <= act_nxt;
      raddr_q   <= raddr_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      fail_q    <= fail_nxt;
    end
  end

  // Next state and next register values.
  always_comb begin
    state_nxt   = state;
    row_nxt     = row_cnt;
    run_nxt     = run_cnt;
    chk_nxt     = chk_cnt;
    pat_nxt     = pat_q;
    rd_addr_nxt = rd_addr_q;
    raddr_nxt   = raddr_q;
    fail_nxt    = fail_q;
    wr_en_nxt   = 1'b0;
    ws_nxt      = 1'b0;
    rd_en_nxt   = 1'b0;
    act_nxt     = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nxt = S_LOAD_FAULT;
          fail_nxt  = 1'b0;
        end
      end
      S_LOAD_FAULT: begin
        if (bus.envm_rdy) begin
          pat_nxt   = bus.envm_pattern;
          wr_en_nxt = 1'b1;
          state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        ws_nxt    = 1'b1;
        row_nxt   = '0;
        state_nxt = S_FETCH;
      end
      // The weight_start cycle issues no read, so the first weight_valid lands two cycles later.
      S_FETCH: begin
        rd_en_nxt   = 1'b1;
        rd_addr_nxt = row_cnt;
        if (row_cnt == LAST_ROW) state_nxt = S_DRAIN;
        else                     row_nxt   = row_cnt + ADDR_WIDTH'(1);
      end
      S_DRAIN: begin
        chk_nxt = '0;
        if (!rd_en_q) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (bus.recovery_done) begin
          if (bus.recovery_success) begin
            run_nxt   = '0;
            state_nxt = S_RUN;
          end else begin
            fail_nxt  = 1'b1;
            state_nxt = S_FINISH;
          end
        end else if (chk_cnt == CHK_LAST) begin
          fail_nxt  = 1'b1;
          state_nxt = S_FINISH;
        end else begin
          chk_nxt = chk_cnt + 2'd1;
        end
      end
      S_RUN: begin
        if (!bus.stall) begin
          act_nxt   = 1'b1;
          raddr_nxt = run_cnt;
          if (run_cnt == LAST_ROW) state_nxt = S_FINISH;
          else                     run_nxt   = run_cnt + ADDR_WIDTH'(1);
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    if (bus.abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      pat_nxt   = pat_q;
      fail_nxt  = fail_q;
      wr_en_nxt = 1'b0;
      ws_nxt    = 1'b0;
      rd_en_nxt = 1'b0;
      act_nxt   = 1'b0;
    end

    wv_nxt   = rd_en_q && !bus.abort;
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_FINISH);
  end

  assign bus.envm_wr_en                = wr_en_q;
  assign bus.envm_faulty_patterns_flat = pat_q;
  assign bus.wmem_rd_en                = rd_en_q;
  assign bus.wmem_rd_addr              = rd_addr_q;
  assign bus.weight_start              = ws_q;
  assign bus.weight_valid              = wv_q;
  // Forwards the weight memory's registered read port while weight_valid is high.
  assign bus.input_weights             = wv_q ? bus.wmem_rd_data : '0;
  assign bus.read_addr                 = raddr_q;
  assign bus.act_valid                 = act_q;
  assign bus.busy                      = busy_q;
  assign bus.done                      = done_q;
  assign bus.fail                      = fail_q;
endmodule

// File: doc/bisr_alloc_controller.md
BISR_ALLOC_CONTROLLER -- requirements
Module: bisr_alloc_controller

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 8, array rows/columns (N).
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 8, bits per weight.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(SYSTOLIC_SIZE), row address width.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  host request for one allocate+run sequence; honoured only in IDLE.
REQ-007 abort  in  1  synchronous abort; returns to IDLE from any state.
REQ-008 envm_rdy  in  1  eNVM fault pattern valid.
REQ-009 envm_pattern  in  N*N  faulty-PE bitmap from eNVM.
REQ-010 envm_wr_en  out  1  one-cycle load strobe to allocator fault storage.
REQ-011 envm_faulty_patterns_flat  out  N*N  registered copy of envm_pattern.
REQ-012 wmem_rd_en  out  1  weight memory read request.
REQ-013 wmem_rd_addr  out  ADDR_WIDTH  weight memory row address.
REQ-014 wmem_rd_data  in  N*WEIGHT_WIDTH  weight row, valid one cycle after wmem_rd_en.
REQ-015 weight_start  out  1  one-cycle allocator restart pulse.
REQ-016 weight_valid  out  1  input_weights valid to allocator.
REQ-017 input_weights  out  N*WEIGHT_WIDTH  weight row to allocator.
REQ-018 recovery_done, recovery_success  in  1 each  allocator result.
REQ-019 stall  in  1  holds the RUN address counter.
REQ-020 read_addr  out  ADDR_WIDTH  row read address to allocator during RUN.
REQ-021 act_valid  out  1  read_addr valid this cycle.
REQ-022 busy, done, fail  out  1 each  status: busy = not IDLE; done = one-cycle completion pulse; fail = sticky allocation failure.

Function
REQ-023 States SHALL be IDLE, LOAD_FAULT, INIT, FETCH, DRAIN, CHECK, RUN, FINISH; all outputs registered.
REQ-024 IDLE: start=1 -> LOAD_FAULT; fail cleared same edge.
REQ-025 LOAD_FAULT: wait for envm_rdy; on envm_rdy=1 capture envm_pattern into envm_faulty_patterns_flat, envm_wr_en=1 for exactly the next cycle, -> INIT.
REQ-026 INIT: weight_start=1 for exactly one cycle, row counter cleared to 0, -> FETCH.
REQ-027 FETCH: wmem_rd_en=1 with wmem_rd_addr = row counter 0..N-1 on N consecutive cycles; after row N-1 -> DRAIN.
REQ-028 weight_valid SHALL be asserted exactly one cycle after each wmem_rd_en, with input_weights = wmem_rd_data of that cycle; N consecutive weight_valid cycles, the last one occurring in DRAIN.
REQ-029 weight_valid SHALL never coincide with weight_start; the first weight_valid is no earlier than two cycles after weight_start.
REQ-030 CHECK: sample recovery_done; if recovery_done=1 and recovery_success=1 -> RUN; if recovery_done=1 and recovery_success=0, set fail=1 -> FINISH.
REQ-031 CHECK timeout: if recovery_done stays 0 for 4 cycles, set fail=1 -> FINISH.
REQ-032 RUN: act_valid=1 and read_addr counts 0..N-1, incrementing only when stall=0; with stall=1, read_addr holds and act_valid=0.
REQ-033 After read_addr=N-1 is issued with stall=0 -> FINISH; the counter does not wrap.
REQ-034 FINISH: done=1 for one cycle, -> IDLE; fail holds until the next accepted start.
REQ-035 abort=1 in any non-IDLE state: next state IDLE; all strobes and valids are 0 the following cycle; done not pulsed; fail unchanged. abort overrides start.
REQ-036 start outside IDLE SHALL be ignored; start and abort in the same cycle in IDLE -> stay IDLE.
REQ-037 Row and address counters SHALL be ADDR_WIDTH bits; comparisons against N-1 only.

Reset
REQ-038 On rst_n=0: state IDLE; every output 0 (envm_faulty_patterns_flat, input_weights, addresses all-zero; busy/done/fail 0); counters 0.
REQ-039 Reset mid-sequence SHALL abandon the sequence immediately; no done pulse after release.

Verification
REQ-040 N=8, start, envm_rdy after 3 cycles, pattern 0 -> envm_wr_en 1 cycle; weight_start 1 cycle; 8 rd_en rows 0..7; 8 weight_valid with matching data; success -> read_addr 0..7; done pulse; fail=0.
REQ-041 recovery_success=0 at CHECK -> no RUN, act_valid never 1, fail=1, done pulse, fail stays 1 until next start.
REQ-042 recovery_done held 0 -> fail=1 after 4 CHECK cycles, done pulse.
REQ-043 stall=1 for 3 cycles at read_addr=4 -> read_addr holds 4, act_valid=0 for 3 cycles, then 5..7; total 8 act_valid cycles.
REQ-044 abort during FETCH at row 3 -> IDLE next cycle, no further rd_en/weight_valid, no done; new start then runs a full sequence cleanly.
REQ-045 rst_n low during RUN -> all outputs 0 asynchronously; after release busy=0 and start is accepted.
